// File: rtl/infra_seq_pkg.sv
// Shared definitions for the infrastructure reset sequencer: state encoding,
// lock-loss counter limit and state classification helpers.
package infra_seq_pkg;

    localparam int STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        ST_WAIT_LOCK = 3'd0,
        ST_STABLE    = 3'd1,
        ST_IDLY_RST  = 3'd2,
        ST_IDLY_WAIT = 3'd3,
        ST_RUN       = 3'd4,
        ST_FAULT     = 3'd5
    } seq_state_e;

    localparam logic [7:0] LOCK_LOSS_MAX = 8'd255;

    // States in which a dropped lock aborts back to WAIT_LOCK.
    function automatic logic lock_guarded(input seq_state_e st);
        case (st)
            ST_STABLE, ST_IDLY_RST, ST_IDLY_WAIT, ST_RUN: lock_guarded = 1'b1;
            default:                                      lock_guarded = 1'b0;
        endcase
    endfunction

    // States that time themselves with the shared cycle counter.
    function automatic logic uses_counter(input seq_state_e st);
        case (st)
            ST_STABLE, ST_IDLY_RST, ST_IDLY_WAIT: uses_counter = 1'b1;
            default:                              uses_counter = 1'b0;
        endcase
    endfunction

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        max3 = (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/infra_sync2.sv
// Two-flop synchroniser for a single asynchronous level into the clk domain;
// both stages clear while rst_n is low.
module infra_sync2 (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta_r;
    logic sync_r;

    // Two-stage capture of the asynchronous input.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_r <= 1'b0;
            sync_r <= 1'b0;
        end else begin
            meta_r <= d;
            sync_r <= meta_r;
        end
    end

    assign q = sync_r;

endmodule

// File: rtl/infra_reset_sequencer.sv
// Power-up sequencer: waits for a stable clock lock, pulses IDELAYCTRL reset,
// waits for ready, then releases user reset. Define INFRA_SEQ_LOCK_LOSS_CNT_EN
// to build the saturating lock-loss event counter.
module infra_reset_sequencer
    import infra_seq_pkg::*;
#(
    parameter int LOCK_STABLE_CYC = 1024,
    parameter int IDLY_RST_CYC    = 16,
    parameter int RDY_TIMEOUT_CYC = 4096
) (
    input  logic               sys_clk,
    input  logic               sys_rst_n,
    input  logic               sys_clk_lock,
    input  logic               idelay_rdy,
    input  logic               soft_rst,
    output logic               idelay_rst,
    output logic               user_rst,
    output logic               seq_ready,
    output logic               seq_fault,
    output logic [STATE_W-1:0] seq_state,
    output logic [7:0]         lock_loss_cnt
);

    localparam int MAX_CYC = max3(LOCK_STABLE_CYC, IDLY_RST_CYC, RDY_TIMEOUT_CYC);
    localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

    localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(LOCK_STABLE_CYC - 1);
    localparam logic [CNT_W-1:0] IDLY_LAST    = CNT_W'(IDLY_RST_CYC - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(RDY_TIMEOUT_CYC - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO     = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX      = {CNT_W{1'b1}};

    logic             lock_s;
    logic             rdy_s;
    seq_state_e       state_r;
    seq_state_e       state_nxt_s;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_nxt_s;

    logic idelay_rst_r, user_rst_r, seq_ready_r, seq_fault_r;
    logic idelay_rst_nxt_s, user_rst_nxt_s, seq_ready_nxt_s, seq_fault_nxt_s;

    infra_sync2 u_sync_lock (
        .clk   (sys_clk),
        .rst_n (sys_rst_n),
        .d     (sys_clk_lock),
        .q     (lock_s)
    );

    infra_sync2 u_sync_rdy (
        .clk   (sys_clk),
        .rst_n (sys_rst_n),
        .d     (idelay_rdy),
        .q     (rdy_s)
    );

    // State and cycle-counter register; reset release is assumed already synchronised upstream.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_r <= ST_WAIT_LOCK;
            cnt_r   <= CNT_ZERO;
        end else begin
            state_r <= state_nxt_s;
            cnt_r   <= cnt_nxt_s;
        end
    end

    // Next-state and counter decode; lock loss outranks every other exit.
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = CNT_ZERO;
        case (state_r)
            ST_WAIT_LOCK: begin
                if (lock_s) state_nxt_s = ST_STABLE;
                else        state_nxt_s = ST_WAIT_LOCK;
            end
            ST_STABLE: begin
                if (!lock_s)                   state_nxt_s = ST_WAIT_LOCK;
                else if (cnt_r == STABLE_LAST) state_nxt_s = ST_IDLY_RST;
                else                           state_nxt_s = ST_STABLE;
            end
            ST_IDLY_RST: begin
                if (!lock_s)                 state_nxt_s = ST_WAIT_LOCK;
                else if (cnt_r == IDLY_LAST) state_nxt_s = ST_IDLY_WAIT;
                else                         state_nxt_s = ST_IDLY_RST;
            end
            ST_IDLY_WAIT: begin
                if (!lock_s)                    state_nxt_s = ST_WAIT_LOCK;
                else if (rdy_s)                 state_nxt_s = ST_RUN;
                else if (cnt_r == TIMEOUT_LAST) state_nxt_s = ST_FAULT;
                else                            state_nxt_s = ST_IDLY_WAIT;
            end
            ST_RUN: begin
                if (!lock_s)                state_nxt_s = ST_WAIT_LOCK;
                else if (soft_rst || !rdy_s) state_nxt_s = ST_IDLY_RST;
                else                        state_nxt_s = ST_RUN;
            end
            ST_FAULT: begin
                if (soft_rst) state_nxt_s = ST_WAIT_LOCK;
                else          state_nxt_s = ST_FAULT;
            end
            default: state_nxt_s = ST_WAIT_LOCK;
        endcase

        // Counter restarts on every state change and saturates rather than wraps.
        if (state_nxt_s != state_r)     cnt_nxt_s = CNT_ZERO;
        else if (!uses_counter(state_r)) cnt_nxt_s = CNT_ZERO;
        else if (cnt_r == CNT_MAX)       cnt_nxt_s = cnt_r;
        else                             cnt_nxt_s = cnt_r + CNT_ONE;
    end

    // Output decode from the next state so registered outputs line up with state_r.
    always_comb begin
        user_rst_nxt_s   = (state_nxt_s != ST_RUN);
        idelay_rst_nxt_s = (state_nxt_s == ST_IDLY_RST);
        seq_ready_nxt_s  = (state_nxt_s == ST_RUN);
        seq_fault_nxt_s  = (state_nxt_s == ST_FAULT);
    end

    // Output register; asynchronous reset drops an in-flight idelay_rst at once.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            user_rst_r   <= 1'b1;
            idelay_rst_r <= 1'b0;
            seq_ready_r  <= 1'b0;
            seq_fault_r  <= 1'b0;
        end else begin
            user_rst_r   <= user_rst_nxt_s;
            idelay_rst_r <= idelay_rst_nxt_s;
            seq_ready_r  <= seq_ready_nxt_s;
            seq_fault_r  <= seq_fault_nxt_s;
        end
    end

    assign user_rst   = user_rst_r;
    assign idelay_rst = idelay_rst_r;
    assign seq_ready  = seq_ready_r;
    assign seq_fault  = seq_fault_r;
    assign seq_state  = state_r;

`ifdef INFRA_SEQ_LOCK_LOSS_CNT_EN
    logic       lock_loss_evt_s;
    logic [7:0] lock_loss_cnt_r;

    assign lock_loss_evt_s = lock_guarded(state_r) && !lock_s;

    // Saturating count of lock-loss aborts.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            lock_loss_cnt_r <= 8'd0;
        end else if (lock_loss_evt_s && (lock_loss_cnt_r != LOCK_LOSS_MAX)) begin
            lock_loss_cnt_r <= lock_loss_cnt_r + 8'd1;
        end else begin
            lock_loss_cnt_r <= lock_loss_cnt_r;
        end
    end

    assign lock_loss_cnt = lock_loss_cnt_r;
`else
    assign lock_loss_cnt = 8'd0;
`endif

endmodule

// File: tb/tb_infra_reset_sequencer.sv
// Directed bench for infra_reset_sequencer with short timing parameters;
// lock-loss expectations follow whether INFRA_SEQ_LOCK_LOSS_CNT_EN is defined.
module tb_infra_reset_sequencer;

    localparam int S_WAIT  = 0;
    localparam int S_STAB  = 1;
    localparam int S_IRST  = 2;
    localparam int S_IWAIT = 3;
    localparam int S_RUN   = 4;
    localparam int S_FAULT = 5;

`ifdef INFRA_SEQ_LOCK_LOSS_CNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       sys_rst_n;
    logic       lock;
    logic       rdy;
    logic       soft_rst;
    logic       idelay_rst;
    logic       user_rst;
    logic       seq_ready;
    logic       seq_fault;
    logic [2:0] seq_state;
    logic [7:0] lock_loss_cnt;

    int checks   = 0;
    int failures = 0;
    int losses   = 0;

    infra_reset_sequencer #(
        .LOCK_STABLE_CYC (8),
        .IDLY_RST_CYC    (4),
        .RDY_TIMEOUT_CYC (16)
    ) dut (
        .sys_clk       (clk),
        .sys_rst_n     (sys_rst_n),
        .sys_clk_lock  (lock),
        .idelay_rdy    (rdy),
        .soft_rst      (soft_rst),
        .idelay_rst    (idelay_rst),
        .user_rst      (user_rst),
        .seq_ready     (seq_ready),
        .seq_fault     (seq_fault),
        .seq_state     (seq_state),
        .lock_loss_cnt (lock_loss_cnt)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int exp_loss(input int n);
        if (!CNT_EN) return 0;
        return (n > 255) ? 255 : n;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        sys_rst_n = 1'b0;
        lock      = 1'b0;
        rdy       = 1'b0;
        soft_rst  = 1'b0;
        tick(3);
        chk("rst_state", seq_state, S_WAIT);
        chk("rst_user_rst", user_rst, 1);
        chk("rst_idelay_rst", idelay_rst, 0);
        chk("rst_ready", seq_ready, 0);
        chk("rst_fault", seq_fault, 0);
        chk("rst_loss_cnt", lock_loss_cnt, 0);
        sys_rst_n = 1'b1;
        tick(2);
        chk("idle_no_lock", seq_state, S_WAIT);

        // Normal bring-up: two synchroniser cycles then STABLE.
        lock = 1'b1;
        tick(2);
        chk("lock_sync_latency", seq_state, S_WAIT);
        tick(1);
        chk("enter_stable", seq_state, S_STAB);
        tick(7);
        chk("stable_last", seq_state, S_STAB);
        chk("stable_no_idrst", idelay_rst, 0);
        tick(1);
        chk("enter_idly_rst", seq_state, S_IRST);
        chk("idrst_rise", idelay_rst, 1);
        tick(3);
        chk("idrst_4th", idelay_rst, 1);
        tick(1);
        chk("enter_idly_wait", seq_state, S_IWAIT);
        chk("idrst_fall", idelay_rst, 0);
        tick(4);
        rdy = 1'b1;
        tick(2);
        chk("rdy_sync_wait", seq_state, S_IWAIT);
        tick(1);
        chk("enter_run", seq_state, S_RUN);
        chk("run_ready", seq_ready, 1);
        chk("run_user_rst", user_rst, 0);

        // Soft reset in RUN re-pulses idelay_rst, skipping STABLE.
        soft_rst = 1'b1;
        tick(1);
        soft_rst = 1'b0;
        chk("soft_to_idrst", seq_state, S_IRST);
        chk("soft_idrst", idelay_rst, 1);
        chk("soft_user_rst", user_rst, 1);
        tick(3);
        chk("soft_idrst_hold", idelay_rst, 1);
        tick(1);
        chk("soft_idly_wait", seq_state, S_IWAIT);
        tick(1);
        chk("soft_back_run", seq_state, S_RUN);

        // Single synchronised lock drop in RUN.
        lock = 1'b0;
        tick(1);
        lock = 1'b1;
        tick(1);
        chk("loss_pending", seq_state, S_RUN);
        tick(1);
        losses++;
        chk("loss_to_wait", seq_state, S_WAIT);
        chk("loss_user_rst", user_rst, 1);
        chk("loss_cnt_1", lock_loss_cnt, exp_loss(losses));
        tick(1);
        chk("loss_restable", seq_state, S_STAB);
        tick(8);
        chk("loss_idrst", seq_state, S_IRST);
        tick(4);
        chk("loss_iwait", seq_state, S_IWAIT);
        tick(1);
        chk("loss_run", seq_state, S_RUN);

        // soft_rst and lock loss in the same RUN cycle: lock loss wins.
        lock = 1'b0;
        tick(2);
        chk("simul_pre", seq_state, S_RUN);
        soft_rst = 1'b1;
        tick(1);
        soft_rst = 1'b0;
        losses++;
        chk("simul_to_wait", seq_state, S_WAIT);
        chk("simul_cnt", lock_loss_cnt, exp_loss(losses));
        lock = 1'b1;
        tick(3);
        chk("simul_restable", seq_state, S_STAB);

        // Repeated drops during STABLE up to 300 events.
        for (int i = 0; i < 298; i++) begin
            lock = 1'b0;
            tick(1);
            lock = 1'b1;
            tick(3);
            losses++;
        end
        chk("loss_sat_cnt", lock_loss_cnt, exp_loss(losses));
        chk("loss_sat_state", seq_state, S_STAB);

        // Timeout with rdy low.
        rdy = 1'b0;
        tick(8);
        chk("to_idrst", seq_state, S_IRST);
        tick(4);
        chk("to_iwait", seq_state, S_IWAIT);
        tick(15);
        chk("to_before", seq_state, S_IWAIT);
        tick(1);
        chk("to_fault", seq_state, S_FAULT);
        chk("to_fault_flag", seq_fault, 1);
        chk("to_fault_user", user_rst, 1);
        chk("to_fault_ready", seq_ready, 0);
        lock = 1'b0;
        tick(4);
        chk("fault_sticky", seq_state, S_FAULT);
        chk("fault_no_loss", lock_loss_cnt, exp_loss(losses));
        lock = 1'b1;
        tick(3);
        soft_rst = 1'b1;
        tick(1);
        soft_rst = 1'b0;
        chk("fault_soft_wait", seq_state, S_WAIT);
        chk("fault_cleared", seq_fault, 0);

        // Asynchronous reset during the second idelay_rst cycle.
        tick(1);
        chk("re_stable", seq_state, S_STAB);
        tick(8);
        tick(1);
        chk("mid_idrst", idelay_rst, 1);
        sys_rst_n = 1'b0;
        #1;
        chk("abort_idrst", idelay_rst, 0);
        chk("abort_state", seq_state, S_WAIT);
        chk("abort_user_rst", user_rst, 1);
        chk("abort_loss_cnt", lock_loss_cnt, 0);
        tick(2);
        sys_rst_n = 1'b1;
        tick(2);
        chk("post_rst_wait", seq_state, S_WAIT);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/infra_reset_sequencer.md
INFRA_RESET_SEQUENCER -- requirements
Module: infra_reset_sequencer

Interface
REQ-001 Parameter LOCK_STABLE_CYC, default 1024: cycles sys_clk_lock must stay high before IDELAY calibration starts.
REQ-002 Parameter IDLY_RST_CYC, default 16: width of the idelay_rst pulse, in cycles.
REQ-003 Parameter RDY_TIMEOUT_CYC, default 4096: maximum wait for idelay_rdy before the block declares a fault.
REQ-004 sys_clk  in  1  the only clock; all logic on its rising edge.
REQ-005 sys_rst_n  in  1  reset; asynchronous assert, active-low.
REQ-006 sys_clk_lock  in  1  clock-manager lock; asynchronous to sys_clk.
REQ-007 idelay_rdy  in  1  IDELAYCTRL ready; asynchronous to sys_clk.
REQ-008 soft_rst  in  1  synchronous one-cycle software reset request.
REQ-009 idelay_rst  out  1  active-high reset to IDELAYCTRL.
REQ-010 user_rst  out  1  active-high reset to the user fabric.
REQ-011 seq_ready  out  1  high only while the block is in RUN.
REQ-012 seq_fault  out  1  high only while the block is in FAULT.
REQ-013 seq_state  out  3  current state encoding.
REQ-014 lock_loss_cnt  out  8  count of lock-loss events.

Function
REQ-015 sys_clk_lock and idelay_rdy SHALL each pass through a 2-flop synchroniser, giving lock_s and rdy_s; input-to-lock_s latency is 2 cycles.
REQ-016 State encodings SHALL be: WAIT_LOCK=0, STABLE=1, IDLY_RST=2, IDLY_WAIT=3, RUN=4, FAULT=5.
REQ-017 WAIT_LOCK: lock_s=1 -> STABLE, with the cycle counter cleared.
REQ-018 STABLE: the counter increments each cycle; when it reaches LOCK_STABLE_CYC-1 -> IDLY_RST, with the counter cleared.
REQ-019 IDLY_RST: idelay_rst=1 for exactly IDLY_RST_CYC cycles, then -> IDLY_WAIT, with the counter cleared.
REQ-020 IDLY_WAIT: rdy_s=1 -> RUN; if the counter reaches RDY_TIMEOUT_CYC-1 first -> FAULT.
REQ-021 RUN: soft_rst=1 -> IDLY_RST; rdy_s=0 -> IDLY_RST.
REQ-022 FAULT: the state is sticky; soft_rst=1 -> WAIT_LOCK; lock_s changes are ignored.
REQ-023 In STABLE, IDLY_RST, IDLY_WAIT and RUN, lock_s=0 SHALL force -> WAIT_LOCK, overriding every other transition including soft_rst.
REQ-024 soft_rst SHALL be ignored in WAIT_LOCK, STABLE, IDLY_RST and IDLY_WAIT.
REQ-025 Outputs SHALL be registered Moore decodes of the state register:
  - user_rst=1 in every state except RUN;
  - idelay_rst=1 only in IDLY_RST.
REQ-026 The counter width SHALL be clog2 of the largest parameter; the counter SHALL NOT wrap within any state.
REQ-027 lock_loss_cnt SHALL increment by 1 on each REQ-023 transition, saturating at 255.

Reset
REQ-028 While sys_rst_n=0, the block SHALL hold:
  - state=WAIT_LOCK, counter=0, synchronisers=0;
  - user_rst=1, idelay_rst=0, seq_ready=0, seq_fault=0, lock_loss_cnt=0.
REQ-029 sys_rst_n asserted mid-sequence SHALL abort immediately, with no completion of an in-progress idelay_rst pulse; release is synchronous to sys_clk via the existing reset synchroniser.

Configuration
REQ-030 With INFRA_SEQ_LOCK_LOSS_CNT_EN defined, the lock_loss_cnt counter SHALL be built as in REQ-027.
REQ-031 Without INFRA_SEQ_LOCK_LOSS_CNT_EN, lock_loss_cnt SHALL be tied to 0 and no counter logic SHALL be built.

Structure
REQ-032 The state enumeration and its 3-bit width SHALL live in a shared package, infra_seq_pkg.
REQ-033 The 2-flop synchroniser SHALL be a single sub-module, infra_sync2, instantiated twice.

Verification (LOCK_STABLE_CYC=8, IDLY_RST_CYC=4, RDY_TIMEOUT_CYC=16)
REQ-034 Normal bring-up: lock high, rdy rises 5 cycles after idelay_rst falls.
  - State sequence 0->1->2->3->4.
  - idelay_rst rises exactly 8 cycles after entry to STABLE and stays high exactly 4 cycles.
  - seq_ready=1 and user_rst=0 in RUN.
REQ-035 Timeout: rdy held low -> FAULT exactly 16 cycles after entry to IDLY_WAIT, with seq_fault=1; a soft_rst pulse then -> WAIT_LOCK.
REQ-036 Lock loss:
  - lock drops for 1 synchronised cycle in RUN -> WAIT_LOCK, user_rst=1, lock_loss_cnt=1;
  - after 300 such drops, lock_loss_cnt=255.
REQ-037 Simultaneous events: soft_rst and lock loss in the same RUN cycle -> WAIT_LOCK, not IDLY_RST.
REQ-038 Soft reset in RUN: one soft_rst pulse -> a 4-cycle idelay_rst, IDLY_WAIT, then RUN again without passing through STABLE.
REQ-039 Reset mid-operation: sys_rst_n=0 during IDLY_RST cycle 2 -> idelay_rst=0 and state=0 immediately; build without the macro -> lock_loss_cnt stays 0 through scenario REQ-036.
